mem_bus_arbiter: RTL and testbench



---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_arbiter_if.sv | 54 +++++
 rtl/mem_bus_arbiter_slot.sv | 117 +++++++++++
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 486 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_e;

  typedef enum logic {OWN_IB, OWN_DB} arb_owner_e;

  typedef enum logic [SIZE_W-1:0] {
    MEM_SIZE_B = 2'd0,
    MEM_SIZE_H = 2'd1,
    MEM_SIZE_W = 2'd2,
    MEM_SIZE_D = 2'd3
  } mem_size_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Fetch, data and downstream memory signals of the arbiter.
// master: the arbiter's view; slave: the core and memory around it.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              ib_en;
  logic [ADDR_W-1:0] ib_addr;
  logic              ib_ready;
  logic              ib_valid;
  logic [DATA_W-1:0] ib_rdata;
  logic              ib_acc_err;

  logic              db_en;
  logic [ADDR_W-1:0] db_addr;
  logic [1:0]        db_size;
  logic              db_write;
  logic [DATA_W-1:0] db_wdata;
  logic              db_fence_i;
  logic              db_ready;
  logic              db_valid;
  logic [DATA_W-1:0] db_rdata;
  logic              db_acc_err;

  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic [1:0]        m_size;
  logic              m_write;
  logic [DATA_W-1:0] m_wdata;
  logic              m_fence_i;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;

  modport master (
    input  ib_en, ib_addr, ib_ready,
    output ib_valid, ib_rdata, ib_acc_err,
    input  db_en, db_addr, db_size, db_write, db_wdata, db_fence_i, db_ready,
    output db_valid, db_rdata, db_acc_err,
    output m_req, m_addr, m_size, m_write, m_wdata, m_fence_i,
    input  m_gnt, m_rvalid, m_rdata, m_err
  );

  modport slave (
    output ib_en, ib_addr, ib_ready,
    input  ib_valid, ib_rdata, ib_acc_err,
    output db_en, db_addr, db_size, db_write, db_wdata, db_fence_i, db_ready,
    input  db_valid, db_rdata, db_acc_err,
    input  m_req, m_addr, m_size, m_write, m_wdata, m_fence_i,
    output m_gnt, m_rvalid, m_rdata, m_err
  );

endinterface

// File: rtl/mem_bus_arbiter_slot.sv
// One requester slot: latches a request pulse and holds its response
// until the requester accepts it.
module mem_arb_slot
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              write_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              fence_i_i,
  input  logic              ready_i,
  input  logic              done_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              err_i,
  output logic              pend_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [SIZE_W-1:0] size_o,
  output logic              write_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              fence_i_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              acc_err_o,
  output logic              rsp_free_o_c
);

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              fence_q, fence_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  // Request latch and response buffer next-state.
  always_comb begin
    pend_d    = pend_q;
    addr_d    = addr_q;
    size_d    = size_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    fence_d   = fence_q;
    rsp_vld_d = rsp_vld_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    if (en_i && !pend_q) begin
      pend_d  = 1'b1;
      addr_d  = addr_i;
      size_d  = size_i;
      write_d = write_i;
      wdata_d = wdata_i;
      fence_d = fence_i_i;
    end else if (done_i) begin
      pend_d = 1'b0;
    end

    if (done_i) begin
      rsp_vld_d = 1'b1;
      rdata_d   = rdata_i;
      err_d     = err_i;
    end else if (rsp_vld_q && ready_i) begin
      rsp_vld_d = 1'b0;
      rdata_d   = '0;
      err_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      fence_q   <= 1'b0;
      rsp_vld_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      fence_q   <= fence_d;
      rsp_vld_q <= rsp_vld_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign pend_o       = pend_q;
  assign addr_o       = addr_q;
  assign size_o       = size_q;
  assign write_o      = write_q;
  assign wdata_o      = wdata_q;
  assign fence_i_o    = fence_q;
  assign valid_o      = rsp_vld_q;
  assign rdata_o      = rdata_q;
  assign acc_err_o    = err_q;
  assign rsp_free_o_c = !rsp_vld_q || ready_i;

  // A new pulse while a request is still latched would be lost.
  a_no_en_while_pend : assert property (@(posedge clk_i) disable iff (rst_i)
    !(en_i && pend_q))
    else $error("mem_arb_slot: en asserted while a request is pending");

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between the fetch and data buses.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise data has fixed priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input logic               clock,
  input logic               reset,
  mem_bus_arbiter_if.master bus
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;

  logic              ib_pend, db_pend;
  logic              ib_free_c, db_free_c;
  logic              ib_done, db_done;
  logic              ib_elig, db_elig;
  logic [ADDR_W-1:0] ib_req_addr, db_req_addr;
  logic [SIZE_W-1:0] ib_req_size, db_req_size;
  logic              ib_req_write, db_req_write;
  logic [DATA_W-1:0] ib_req_wdata, db_req_wdata;
  logic              ib_req_fence, db_req_fence;

  assign ib_done = (state_q == WAIT) && bus.m_rvalid && (owner_q == OWN_IB);
  assign db_done = (state_q == WAIT) && bus.m_rvalid && (owner_q == OWN_DB);

  // Fetch slot: fixed word size, never a store or fence.
  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ib_slot (
    .clk_i        (clock),
    .rst_i        (reset),
    .en_i         (bus.ib_en),
    .addr_i       (bus.ib_addr),
    .size_i       (SIZE_W'(MEM_SIZE_W)),
    .write_i      (1'b0),
    .wdata_i      ('0),
    .fence_i_i    (1'b0),
    .ready_i      (bus.ib_ready),
    .done_i       (ib_done),
    .rdata_i      (bus.m_rdata),
    .err_i        (bus.m_err),
    .pend_o       (ib_pend),
    .addr_o       (ib_req_addr),
    .size_o       (ib_req_size),
    .write_o      (ib_req_write),
    .wdata_o      (ib_req_wdata),
    .fence_i_o    (ib_req_fence),
    .valid_o      (bus.ib_valid),
    .rdata_o      (bus.ib_rdata),
    .acc_err_o    (bus.ib_acc_err),
    .rsp_free_o_c (ib_free_c)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_db_slot (
    .clk_i        (clock),
    .rst_i        (reset),
    .en_i         (bus.db_en),
    .addr_i       (bus.db_addr),
    .size_i       (bus.db_size),
    .write_i      (bus.db_write),
    .wdata_i      (bus.db_wdata),
    .fence_i_i    (bus.db_fence_i),
    .ready_i      (bus.db_ready),
    .done_i       (db_done),
    .rdata_i      (bus.m_rdata),
    .err_i        (bus.m_err),
    .pend_o       (db_pend),
    .addr_o       (db_req_addr),
    .size_o       (db_req_size),
    .write_o      (db_req_write),
    .wdata_o      (db_req_wdata),
    .fence_i_o    (db_req_fence),
    .valid_o      (bus.db_valid),
    .rdata_o      (bus.db_rdata),
    .acc_err_o    (bus.db_acc_err),
    .rsp_free_o_c (db_free_c)
  );

  // A port with an unconsumed response cannot start another transaction.
  assign ib_elig = ib_pend && ib_free_c;
  assign db_elig = db_pend && db_free_c;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (ib_elig && db_elig) begin
          state_d = REQ;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          owner_d = (owner_q == OWN_DB) ? OWN_IB : OWN_DB;
`else
          owner_d = OWN_DB;
`endif
        end else if (db_elig) begin
          state_d = REQ;
          owner_d = OWN_DB;
        end else if (ib_elig) begin
          state_d = REQ;
          owner_d = OWN_IB;
        end
      end
      REQ:     if (bus.m_gnt)    state_d = WAIT;
      WAIT:    if (bus.m_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_DB;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Downstream fields come straight from the owner's latched request.
  assign bus.m_req     = (state_q == REQ);
  assign bus.m_addr    = (owner_q == OWN_IB) ? ib_req_addr  : db_req_addr;
  assign bus.m_size    = (owner_q == OWN_IB) ? ib_req_size  : db_req_size;
  assign bus.m_write   = (owner_q == OWN_IB) ? ib_req_write : db_req_write;
  assign bus.m_wdata   = (owner_q == OWN_IB) ? ib_req_wdata : db_req_wdata;
  assign bus.m_fence_i = (owner_q == OWN_IB) ? ib_req_fence : db_req_fence;

  a_rvalid_in_wait : assert property (@(posedge clock) disable iff (reset)
    bus.m_rvalid |-> (state_q == WAIT))
    else $error("mem_bus_arbiter: m_rvalid outside WAIT");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ib_en = 1'b0; bus.ib_addr = '0; bus.ib_ready = 1'b1;
    bus.db_en = 1'b0; bus.db_addr = '0; bus.db_size = 2'd0; bus.db_write = 1'b0;
    bus.db_wdata = '0; bus.db_fence_i = 1'b0; bus.db_ready = 1'b1;
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0; bus.m_err = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.m_req, bus.ib_valid, bus.db_valid, bus.ib_acc_err, bus.db_acc_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000",
               {bus.m_req, bus.ib_valid, bus.db_valid, bus.ib_acc_err, bus.db_acc_err});
    end
    checks++;
    if ({bus.ib_rdata, bus.db_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdata ib=%h db=%h exp=0", bus.ib_rdata, bus.db_rdata);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (bus.m_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle m_req=%b exp=0", bus.m_req);
    end
  endtask

  task automatic test_single_load();
    do_reset();
    bus.db_en = 1'b1; bus.db_addr = 64'h8000_0010; bus.db_size = 2'd3; bus.db_write = 1'b0;
    tick();  // N+1
    bus.db_en = 1'b0;
    checks++;
    if (bus.m_req !== 1'b0) begin
      errors++; $display("FAIL load_n1_mreq got=%b exp=0", bus.m_req);
    end
    tick();  // N+2
    checks++;
    if ({bus.m_req, bus.m_addr, bus.m_size, bus.m_write} !== {1'b1, 64'h8000_0010, 2'd3, 1'b0}) begin
      errors++;
      $display("FAIL load_n2_req req=%b addr=%h size=%0d wr=%b exp 1/80000010/3/0",
               bus.m_req, bus.m_addr, bus.m_size, bus.m_write);
    end
    bus.m_gnt = 1'b1;
    tick();  // N+3
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'h1122334455667788; bus.m_err = 1'b0;
    checks++;
    if (bus.db_valid !== 1'b0) begin
      errors++; $display("FAIL load_n3_valid got=%b exp=0", bus.db_valid);
    end
    tick();  // N+4
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    checks++;
    if ({bus.db_valid, bus.db_rdata, bus.db_acc_err, bus.ib_valid} !==
        {1'b1, 64'h1122334455667788, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL load_n4_rsp valid=%b data=%h err=%b ibv=%b exp 1/1122334455667788/0/0",
               bus.db_valid, bus.db_rdata, bus.db_acc_err, bus.ib_valid);
    end
    tick();
    checks++;
    if (bus.db_valid !== 1'b0) begin
      errors++; $display("FAIL load_consumed valid=%b exp=0", bus.db_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic       first_ib;
    logic [1:0] sz_first, sz_second;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    first_ib = 1'b1;
`else
    first_ib = 1'b0;
`endif
    sz_first  = first_ib ? 2'd2 : 2'd3;
    sz_second = first_ib ? 2'd3 : 2'd2;
    do_reset();
    bus.ib_en = 1'b1; bus.ib_addr = 64'h1000;
    bus.db_en = 1'b1; bus.db_addr = 64'h1000; bus.db_size = 2'd3; bus.db_write = 1'b0;
    tick();
    bus.ib_en = 1'b0; bus.db_en = 1'b0;
    tick();  // N+2
    checks++;
    if ({bus.m_req, bus.m_addr, bus.m_size} !== {1'b1, 64'h1000, sz_first}) begin
      errors++;
      $display("FAIL simul_first req=%b addr=%h size=%0d exp 1/1000/%0d",
               bus.m_req, bus.m_addr, bus.m_size, sz_first);
    end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'hAAAA_0001;
    tick();  // N+4
    bus.m_rvalid = 1'b0;
    checks++;
    if ({bus.ib_valid, bus.db_valid} !== {first_ib, !first_ib}) begin
      errors++;
      $display("FAIL simul_first_rsp ibv=%b dbv=%b exp %b/%b",
               bus.ib_valid, bus.db_valid, first_ib, !first_ib);
    end
    checks++;
    if ((first_ib ? bus.ib_rdata : bus.db_rdata) !== 64'hAAAA_0001) begin
      errors++;
      $display("FAIL simul_first_data got=%h exp=aaaa0001",
               first_ib ? bus.ib_rdata : bus.db_rdata);
    end
    checks++;
    if (bus.m_req !== 1'b0) begin
      errors++; $display("FAIL simul_gap m_req=%b exp=0", bus.m_req);
    end
    tick();  // N+5
    checks++;
    if ({bus.m_req, bus.m_size} !== {1'b1, sz_second}) begin
      errors++;
      $display("FAIL simul_second req=%b size=%0d exp 1/%0d", bus.m_req, bus.m_size, sz_second);
    end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'hBBBB_0002;
    tick();
    bus.m_rvalid = 1'b0;
    checks++;
    if ({bus.ib_valid, bus.db_valid, first_ib ? bus.db_rdata : bus.ib_rdata} !==
        {!first_ib, first_ib, 64'hBBBB_0002}) begin
      errors++;
      $display("FAIL simul_second_rsp ibv=%b dbv=%b data=%h exp %b/%b/bbbb0002",
               bus.ib_valid, bus.db_valid, first_ib ? bus.db_rdata : bus.ib_rdata,
               !first_ib, first_ib);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.db_ready = 1'b0;
    bus.db_en = 1'b1; bus.db_addr = 64'h3000; bus.db_size = 2'd3;
    tick();
    bus.db_en = 1'b0;
    tick();
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'hC0C0;
    tick();  // V
    bus.m_rvalid = 1'b0;
    checks++;
    if ({bus.db_valid, bus.db_rdata} !== {1'b1, 64'hC0C0}) begin
      errors++; $display("FAIL bp_first valid=%b data=%h exp 1/c0c0", bus.db_valid, bus.db_rdata);
    end
    bus.db_en = 1'b1; bus.db_addr = 64'h3008;
    bus.ib_en = 1'b1; bus.ib_addr = 64'h4000;
    tick();  // V+1
    bus.db_en = 1'b0; bus.ib_en = 1'b0;
    tick();  // V+2
    checks++;
    if ({bus.m_req, bus.m_addr, bus.m_size} !== {1'b1, 64'h4000, 2'd2}) begin
      errors++;
      $display("FAIL bp_ib_served req=%b addr=%h size=%0d exp 1/4000/2",
               bus.m_req, bus.m_addr, bus.m_size);
    end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'hD0D0;
    tick();  // V+4
    bus.m_rvalid = 1'b0;
    checks++;
    if ({bus.ib_valid, bus.ib_rdata, bus.db_valid, bus.db_rdata, bus.m_req} !==
        {1'b1, 64'hD0D0, 1'b1, 64'hC0C0, 1'b0}) begin
      errors++;
      $display("FAIL bp_v4 ibv=%b ibd=%h dbv=%b dbd=%h mreq=%b exp 1/d0d0/1/c0c0/0",
               bus.ib_valid, bus.ib_rdata, bus.db_valid, bus.db_rdata, bus.m_req);
    end
    tick();  // V+5
    checks++;
    if ({bus.m_req, bus.db_valid, bus.db_rdata} !== {1'b0, 1'b1, 64'hC0C0}) begin
      errors++;
      $display("FAIL bp_v5_held mreq=%b dbv=%b dbd=%h exp 0/1/c0c0",
               bus.m_req, bus.db_valid, bus.db_rdata);
    end
    bus.db_ready = 1'b1;
    tick();  // V+6
    checks++;
    if ({bus.m_req, bus.m_addr, bus.db_valid} !== {1'b1, 64'h3008, 1'b0}) begin
      errors++;
      $display("FAIL bp_db_issued req=%b addr=%h dbv=%b exp 1/3008/0",
               bus.m_req, bus.m_addr, bus.db_valid);
    end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 64'hE0E0;
    tick();
    bus.m_rvalid = 1'b0;
    checks++;
    if ({bus.db_valid, bus.db_rdata} !== {1'b1, 64'hE0E0}) begin
      errors++; $display("FAIL bp_second valid=%b data=%h exp 1/e0e0", bus.db_valid, bus.db_rdata);
    end
    tick();
  endtask

  task automatic test_store_fault();
    do_reset();
    bus.db_en = 1'b1; bus.db_addr = 64'h2000; bus.db_size = 2'd0;
    bus.db_write = 1'b1; bus.db_wdata = 64'hAB;
    tick();
    bus.db_en = 1'b0; bus.db_write = 1'b0; bus.db_wdata = '0;
    tick();  // N+2
    checks++;
    if ({bus.m_req, bus.m_write, bus.m_wdata, bus.m_size, bus.m_fence_i} !==
        {1'b1, 1'b1, 64'hAB, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL store_req req=%b wr=%b wdata=%h size=%0d fence=%b exp 1/1/ab/0/0",
               bus.m_req, bus.m_write, bus.m_wdata, bus.m_size, bus.m_fence_i);
    end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_err = 1'b1;
    tick();  // N+4
    bus.m_rvalid = 1'b0; bus.m_err = 1'b0;
    checks++;
    if ({bus.db_valid, bus.db_acc_err, bus.ib_acc_err} !== 3'b110) begin
      errors++;
      $display("FAIL store_fault valid=%b acc_err=%b ib_err=%b exp 1/1/0",
               bus.db_valid, bus.db_acc_err, bus.ib_acc_err);
    end
    tick();
  endtask

  task automatic test_gnt_delay();
    int hi;
    do_reset();
    hi = 0;
    bus.db_en = 1'b1; bus.db_addr = 64'h5000; bus.db_size = 2'd2;
    tick();  // N+1
    bus.db_en = 1'b0; bus.db_addr = 64'hFFFF;
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (bus.m_req !== ((c >= 2) && (c <= 5))) begin
        errors++;
        $display("FAIL gdly_mreq_c%0d got=%b exp=%b", c, bus.m_req, (c >= 2) && (c <= 5));
      end
      if (bus.m_req === 1'b1) begin
        hi++;
        checks++;
        if ({bus.m_addr, bus.m_size} !== {64'h5000, 2'd2}) begin
          errors++;
          $display("FAIL gdly_fields_c%0d addr=%h size=%0d exp 5000/2", c, bus.m_addr, bus.m_size);
        end
      end
      checks++;
      if (bus.db_valid !== 1'b0) begin
        errors++; $display("FAIL gdly_early_valid_c%0d got=%b exp=0", c, bus.db_valid);
      end
      bus.m_gnt = (c == 5);
      bus.m_rvalid = (c == 8);
      bus.m_rdata = 64'h0099;
      tick();
    end
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0;
    checks++;
    if ({bus.db_valid, bus.db_rdata, 32'(hi)} !== {1'b1, 64'h0099, 32'd4}) begin
      errors++;
      $display("FAIL gdly_n9 valid=%b data=%h req_cycles=%0d exp 1/0099/4",
               bus.db_valid, bus.db_rdata, hi);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.db_en = 1'b1; bus.db_addr = 64'h6000; bus.db_size = 2'd3;
    tick();
    bus.db_en = 1'b0;
    tick();
    bus.m_gnt = 1'b1;
    tick();  // WAIT
    bus.m_gnt = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.m_req, bus.db_valid, bus.db_acc_err, bus.db_rdata} !== 67'h0) begin
      errors++;
      $display("FAIL rstmid_outputs req=%b dbv=%b err=%b data=%h exp all 0",
               bus.m_req, bus.db_valid, bus.db_acc_err, bus.db_rdata);
    end
    bus.m_rvalid = 1'b1; bus.m_rdata = 64'hDEAD;
    tick();
    bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.m_req, bus.db_valid, bus.ib_valid} !== 3'b0) begin
        errors++;
        $display("FAIL rstmid_quiet_c%0d req=%b dbv=%b ibv=%b exp 0/0/0",
                 c, bus.m_req, bus.db_valid, bus.ib_valid);
      end
      tick();
    end
    bus.db_en = 1'b1; bus.db_addr = 64'h6100;
    tick();
    bus.db_en = 1'b0;
    tick();
    checks++;
    if ({bus.m_req, bus.m_addr} !== {1'b1, 64'h6100}) begin
      errors++;
      $display("FAIL rstmid_recover req=%b addr=%h exp 1/6100", bus.m_req, bus.m_addr);
    end
    bus.m_gnt = 1'b1;
    tick();
    bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1;
    tick();
    bus.m_rvalid = 1'b0;
    tick();
  endtask

  // Random traffic; ib addresses have bit 63 clear, db addresses have it set,
  // so the memory model can tell which requester a transaction belongs to.
  task automatic test_random();
    rsp_t              ib_q[$];
    rsp_t              db_q[$];
    logic              ib_pend, db_pend;
    logic [ADDR_W-1:0] ib_a, db_a;
    logic [1:0]        db_sz;
    logic              db_wr, db_fe;
    logic [DATA_W-1:0] db_wd;
    int                phase, delay;
    logic              own_ib;
    logic              drain;
    rsp_t              r;
    do_reset();
    ib_pend = 1'b0; db_pend = 1'b0; phase = 0; delay = 0; own_ib = 1'b0;
    ib_a = '0; db_a = '0; db_sz = '0; db_wr = 1'b0; db_fe = 1'b0; db_wd = '0;
    for (int cyc = 0; cyc < 2080; cyc++) begin
      drain = (cyc >= 2000);
      bus.ib_ready = drain || ($urandom_range(0, 9) < 7);
      bus.db_ready = drain || ($urandom_range(0, 9) < 7);

      if (bus.ib_valid === 1'b1) begin
        checks++;
        if (ib_q.size() == 0) begin
          errors++; $display("FAIL rnd_ib_unexpected cyc=%0d data=%h", cyc, bus.ib_rdata);
        end else if ({bus.ib_rdata, bus.ib_acc_err} !== {ib_q[0].data, ib_q[0].err}) begin
          errors++;
          $display("FAIL rnd_ib_rsp cyc=%0d got=%h/%b exp=%h/%b",
                   cyc, bus.ib_rdata, bus.ib_acc_err, ib_q[0].data, ib_q[0].err);
        end
        if (bus.ib_ready && ib_q.size() > 0) void'(ib_q.pop_front());
      end
      if (bus.db_valid === 1'b1) begin
        checks++;
        if (db_q.size() == 0) begin
          errors++; $display("FAIL rnd_db_unexpected cyc=%0d data=%h", cyc, bus.db_rdata);
        end else if ({bus.db_rdata, bus.db_acc_err} !== {db_q[0].data, db_q[0].err}) begin
          errors++;
          $display("FAIL rnd_db_rsp cyc=%0d got=%h/%b exp=%h/%b",
                   cyc, bus.db_rdata, bus.db_acc_err, db_q[0].data, db_q[0].err);
        end
        if (bus.db_ready && db_q.size() > 0) void'(db_q.pop_front());
      end

      bus.ib_addr = {1'b0, 31'($urandom), $urandom};
      bus.db_addr = {1'b1, 31'($urandom), $urandom};
      bus.db_size = 2'($urandom);
      bus.db_write = 1'($urandom);
      bus.db_wdata = {$urandom, $urandom};
      bus.db_fence_i = 1'($urandom);
      bus.ib_en = !drain && !ib_pend && ($urandom_range(0, 3) == 0);
      bus.db_en = !drain && !db_pend && ($urandom_range(0, 3) == 0);
      if (bus.ib_en) begin ib_pend = 1'b1; ib_a = bus.ib_addr; end
      if (bus.db_en) begin
        db_pend = 1'b1; db_a = bus.db_addr; db_sz = bus.db_size;
        db_wr = bus.db_write; db_wd = bus.db_wdata; db_fe = bus.db_fence_i;
      end

      bus.m_gnt = 1'b0;
      bus.m_rvalid = 1'b0;
      if (phase == 0) begin
        if (bus.m_req === 1'b1) begin
          own_ib = !bus.m_addr[ADDR_W-1];
          checks++;
          if (own_ib && !(ib_pend && {bus.m_addr, bus.m_size, bus.m_write, bus.m_wdata, bus.m_fence_i} ===
                                     {ib_a, 2'd2, 1'b0, 64'h0, 1'b0})) begin
            errors++;
            $display("FAIL rnd_ib_req cyc=%0d pend=%b addr=%h size=%0d wr=%b exp addr=%h size=2 wr=0",
                     cyc, ib_pend, bus.m_addr, bus.m_size, bus.m_write, ib_a);
          end else if (!own_ib && !(db_pend && {bus.m_addr, bus.m_size, bus.m_write, bus.m_wdata, bus.m_fence_i} ===
                                              {db_a, db_sz, db_wr, db_wd, db_fe})) begin
            errors++;
            $display("FAIL rnd_db_req cyc=%0d pend=%b addr=%h size=%0d wr=%b exp addr=%h size=%0d wr=%b",
                     cyc, db_pend, bus.m_addr, bus.m_size, bus.m_write, db_a, db_sz, db_wr);
          end
          if ($urandom_range(0, 1) == 1) begin
            bus.m_gnt = 1'b1;
            phase = 1;
            delay = $urandom_range(0, 3);
          end
        end
      end else begin
        checks++;
        if (bus.m_req !== 1'b0) begin
          errors++; $display("FAIL rnd_req_in_wait cyc=%0d m_req=%b exp=0", cyc, bus.m_req);
        end
        if (delay == 0) begin
          r.data = {$urandom, $urandom};
          r.err  = ($urandom_range(0, 7) == 0);
          bus.m_rvalid = 1'b1; bus.m_rdata = r.data; bus.m_err = r.err;
          checks++;
          if ((own_ib ? ib_q.size() : db_q.size()) != 0) begin
            errors++;
            $display("FAIL rnd_rsp_overrun cyc=%0d port_ib=%b held=%0d exp=0",
                     cyc, own_ib, own_ib ? ib_q.size() : db_q.size());
          end
          if (own_ib) begin ib_q.push_back(r); ib_pend = 1'b0; end
          else        begin db_q.push_back(r); db_pend = 1'b0; end
          phase = 0;
        end else begin
          delay--;
        end
      end
      tick();
    end
    checks++;
    if ({ib_pend, db_pend, 32'(ib_q.size()), 32'(db_q.size()), 32'(phase)} !== 67'h0) begin
      errors++;
      $display("FAIL rnd_drain ib_pend=%b db_pend=%b ibq=%0d dbq=%0d phase=%0d exp all 0",
               ib_pend, db_pend, ib_q.size(), db_q.size(), phase);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_simultaneous();
    test_backpressure();
    test_store_fault();
    test_gnt_delay();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
